act_dealloc: RTL and testbench

ACT_DEALLOC -- requirements
Module: act_dealloc

---
 rtl/act_dealloc_if.sv | 74 +++++++
 rtl/act_dealloc.sv | 194 +++++++++++++++++++
 tb/tb_act_dealloc.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/act_dealloc_if.sv
// Shared MPU types and the act_dealloc request/ACT port bundle.
// Ports: slave = scanner side, master = requester/ACT side.

package mpu_common;

  localparam int BLOCK_COUNT      = 16;
  localparam int BLOCK_COUNT_BITS = 4;

  typedef logic [3:0] owner_t;
  typedef logic [7:0] resid_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    resid_t reservation_id;
  } entry_t;

endpackage

interface act_dealloc_if;
  import mpu_common::*;

  logic                      req_valid;
  logic                      req_ready;
  owner_t                    req_owner;
  resid_t                    req_res_id;

  logic                      done_valid;
  logic [BLOCK_COUNT_BITS:0] done_count;
  logic                      done_abort;

  logic                      act_cs;
  logic                      act_sel;
  logic                      act_we;
  logic [BLOCK_COUNT_BITS-1:0] act_addr;
  entry_t                    act_wdata;
  entry_t                    act_rdata;
  logic                      act_bsy;

  modport slave (
    input  req_valid,
    input  req_owner,
    input  req_res_id,
    input  act_rdata,
    input  act_bsy,
    output req_ready,
    output done_valid,
    output done_count,
    output done_abort,
    output act_cs,
    output act_sel,
    output act_we,
    output act_addr,
    output act_wdata
  );

  modport master (
    output req_valid,
    output req_owner,
    output req_res_id,
    output act_rdata,
    output act_bsy,
    input  req_ready,
    input  done_valid,
    input  done_count,
    input  done_abort,
    input  act_cs,
    input  act_sel,
    input  act_we,
    input  act_addr,
    input  act_wdata
  );

endinterface

// File: rtl/act_dealloc.sv
// ACT dealloc scanner: walks every ACT entry, zeroes those owned by the
// requesting core and reports how many were cleared.
// Ports: clk, rst (sync, active high), bus (act_dealloc_if.slave).
// Option: ACT_DEALLOC_RESID_MATCH_EN also requires reservation_id match.

module act_dealloc
  import mpu_common::*;
#(
  parameter int IDLE_GAP = 1
) (
  input logic          clk,
  input logic          rst,
  act_dealloc_if.slave bus
);

  localparam int GW = $clog2(IDLE_GAP + 2) + 1;
  localparam logic [GW-1:0] GAP_MIN =
    GW'(IDLE_GAP + 1);
  localparam logic [BLOCK_COUNT_BITS-1:0] LAST =
    BLOCK_COUNT_BITS'(BLOCK_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    WRITE,
    DONE
  } state_t;

  state_t                      state;
  logic [GW-1:0]               low_cnt;
  logic [BLOCK_COUNT_BITS-1:0] idx;
  logic [BLOCK_COUNT_BITS:0]   count;
  owner_t                      own_q;
`ifdef ACT_DEALLOC_RESID_MATCH_EN
  resid_t                      res_q;
`endif

  logic                        cs_q;
  logic                        we_q;
  logic [BLOCK_COUNT_BITS-1:0] addr_q;
  logic                        done_q;
  logic [BLOCK_COUNT_BITS:0]   dcnt_q;
  logic                        abort_q;

  logic match;
  logic accept;
  logic last;
  logic [BLOCK_COUNT_BITS:0] count_inc;

  // Consecutive sampled-idle cycles of the ACT, saturating.
  // Reset counts as busy so the gap restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      low_cnt <= '0;
    end else if (bus.act_bsy) begin
      low_cnt <= '0;
    end else if (low_cnt != GAP_MIN) begin
      low_cnt <= low_cnt + 1'b1;
    end
  end

  assign bus.req_ready = (state == IDLE) &&
                         (low_cnt == GAP_MIN);
  assign accept = bus.req_valid && bus.req_ready;

`ifdef ACT_DEALLOC_RESID_MATCH_EN
  assign match = bus.act_rdata.valid &&
                 (bus.act_rdata.owner == own_q) &&
                 (bus.act_rdata.reservation_id == res_q);
`else
  assign match = bus.act_rdata.valid &&
                 (bus.act_rdata.owner == own_q);
`endif

  assign last      = (idx == LAST);
  assign count_inc = count + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      count   <= '0;
      own_q   <= '0;
`ifdef ACT_DEALLOC_RESID_MATCH_EN
      res_q   <= '0;
`endif
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      dcnt_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          cs_q <= 1'b0;
          we_q <= 1'b0;
          if (accept) begin
            own_q  <= bus.req_owner;
`ifdef ACT_DEALLOC_RESID_MATCH_EN
            res_q  <= bus.req_res_id;
`endif
            idx    <= '0;
            count  <= '0;
            state  <= READ;
            cs_q   <= 1'b1;
            addr_q <= '0;
          end
        end
        READ: begin
          cs_q <= 1'b0;
          we_q <= 1'b0;
          if (bus.act_bsy) begin
            state   <= DONE;
            done_q  <= 1'b1;
            dcnt_q  <= count;
            abort_q <= 1'b1;
          end else begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (bus.act_bsy) begin
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            state   <= DONE;
            done_q  <= 1'b1;
            dcnt_q  <= count;
            abort_q <= 1'b1;
          end else if (match) begin
            state  <= WRITE;
            cs_q   <= 1'b1;
            we_q   <= 1'b1;
            addr_q <= idx;
          end else if (last) begin
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            state   <= DONE;
            done_q  <= 1'b1;
            dcnt_q  <= count;
            abort_q <= 1'b0;
          end else begin
            idx    <= idx + 1'b1;
            state  <= READ;
            cs_q   <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= idx + 1'b1;
          end
        end
        WRITE: begin
          // The write already went out this cycle,
          // so it is counted even on abort.
          count <= count_inc;
          if (bus.act_bsy || last) begin
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            state   <= DONE;
            done_q  <= 1'b1;
            dcnt_q  <= count_inc;
            abort_q <= bus.act_bsy;
          end else begin
            idx    <= idx + 1'b1;
            state  <= READ;
            cs_q   <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= idx + 1'b1;
          end
        end
        DONE: begin
          cs_q  <= 1'b0;
          we_q  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          cs_q  <= 1'b0;
          we_q  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.act_cs     = cs_q;
  assign bus.act_we     = we_q;
  assign bus.act_addr   = addr_q;
  assign bus.act_sel    = 1'b1;
  assign bus.act_wdata  = '0;
  assign bus.done_valid = done_q;
  assign bus.done_count = dcnt_q;
  assign bus.done_abort = abort_q;

endmodule

// File: tb/tb_act_dealloc.sv
// Bench for act_dealloc: ACT memory model plus a per-request
// reference of which entries must be cleared and when.

module tb_act_dealloc;
  import mpu_common::*;

  localparam int IDLE_GAP = 1;
  localparam int BC = BLOCK_COUNT;
  localparam int EW = $bits(entry_t);
  localparam int CW = BLOCK_COUNT_BITS + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  act_dealloc_if bus();

  act_dealloc #(.IDLE_GAP(IDLE_GAP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad = 0;

  entry_t mem [BC];
  int cs_events = 0;
  int wdata_bad = 0;
  int wr_q[$];

  // ACT model: read data one cycle after a read, junk otherwise.
  always @(posedge clk) begin
    if (bus.act_cs && !bus.act_we)
      bus.act_rdata <= mem[bus.act_addr];
    else
      bus.act_rdata <= EW'($urandom);
    if (bus.act_cs)
      cs_events <= cs_events + 1;
    if (bus.act_cs && bus.act_we) begin
      wr_q.push_back(int'(bus.act_addr));
      if (bus.act_wdata !== '0)
        wdata_bad <= wdata_bad + 1;
    end
  end

  function automatic bit ref_match(entry_t e, owner_t o,
                                   resid_t r);
`ifdef ACT_DEALLOC_RESID_MATCH_EN
    return e.valid && e.owner == o &&
           e.reservation_id == r;
`else
    return e.valid && e.owner == o;
`endif
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < BC; i++) mem[i] = '0;
  endtask

  task automatic run_scan(input owner_t o, input resid_t r,
                          input int abort_at, input bit noise,
                          input string tag);
    int exp_wr[$];
    int got_wr[$];
    int stop, m, exp_cs, exp_lat, base_wr, base_cs, n;
    bit to, rdy_bad;
    stop = (abort_at >= 0) ? abort_at : BC - 1;
    for (int i = 0; i <= stop; i++)
      if (ref_match(mem[i], o, r) && i != abort_at)
        exp_wr.push_back(i);
    m = exp_wr.size();
    exp_cs = stop + 1 + m;
    exp_lat = 1 + 2 * BC + m;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(posedge clk); @(negedge clk); n++;
    end
    total++;
    if (!bus.req_ready) begin
      bad++;
      $display("FAIL %s ready_wait got=0 want=1", tag);
      return;
    end
    base_wr = wr_q.size();
    base_cs = cs_events;
    bus.req_valid = 1'b1;
    bus.req_owner = o;
    bus.req_res_id = r;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_owner = owner_t'($urandom);
    bus.req_res_id = resid_t'($urandom);
    n = 0; to = 0; rdy_bad = 0;
    while (!bus.done_valid) begin
      if (bus.req_ready) rdy_bad = 1;
      if (noise)
        bus.req_valid = (n < 2 * BC - 2) ? 1'($urandom) : 1'b0;
      if (abort_at >= 0 && bus.act_cs && !bus.act_we &&
          int'(bus.act_addr) == abort_at)
        bus.act_bsy = 1'b1;
      if (n > 4 * BC + 10) begin to = 1; break; end
      @(posedge clk); @(negedge clk); n++;
    end
    bus.req_valid = 1'b0;
    total++;
    if (to) begin
      bad++;
      $display("FAIL %s done_timeout cycles=%0d", tag, n);
    end
    total++;
    if (bus.done_count !== CW'(m)) begin
      bad++;
      $display("FAIL %s count got=%0d want=%0d",
               tag, bus.done_count, m);
    end
    total++;
    if (bus.done_abort !== (abort_at >= 0)) begin
      bad++;
      $display("FAIL %s abort got=%0b want=%0b",
               tag, bus.done_abort, abort_at >= 0);
    end
    if (abort_at < 0) begin
      total++;
      if (n + 1 != exp_lat) begin
        bad++;
        $display("FAIL %s latency got=%0d want=%0d",
                 tag, n + 1, exp_lat);
      end
    end
    total++;
    if (rdy_bad) begin
      bad++;
      $display("FAIL %s busy_ready got=1 want=0", tag);
    end
    for (int i = base_wr; i < wr_q.size(); i++)
      got_wr.push_back(wr_q[i]);
    total++;
    if (got_wr != exp_wr) begin
      bad++;
      $display("FAIL %s writes got=%p want=%p",
               tag, got_wr, exp_wr);
    end
    total++;
    if (cs_events - base_cs != exp_cs) begin
      bad++;
      $display("FAIL %s cs_count got=%0d want=%0d",
               tag, cs_events - base_cs, exp_cs);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (bus.done_valid !== 1'b0 ||
        bus.done_count !== CW'(m)) begin
      bad++;
      $display("FAIL %s done_hold got=%0b/%0d want=0/%0d",
               tag, bus.done_valid, bus.done_count, m);
    end
    total++;
    if (wdata_bad != 0) begin
      bad++;
      $display("FAIL %s wdata_nonzero got=%0d want=0",
               tag, wdata_bad);
    end
    bus.act_bsy = 1'b0;
  endtask

  task automatic test_reset();
    int k, base;
    bit rdy_seen;
    rst = 1'b1;
    bus.act_bsy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.req_ready, bus.act_cs, bus.act_we,
         bus.done_valid, bus.done_abort} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=00000",
               {bus.req_ready, bus.act_cs, bus.act_we,
                bus.done_valid, bus.done_abort});
    end
    total++;
    if (bus.act_sel !== 1'b1) begin
      bad++;
      $display("FAIL reset_sel got=%b want=1", bus.act_sel);
    end
    total++;
    if (bus.done_count !== '0 || bus.act_addr !== '0) begin
      bad++;
      $display("FAIL reset_data got=%0d/%0d want=0/0",
               bus.done_count, bus.act_addr);
    end
    rst = 1'b0;
    base = cs_events;
    rdy_seen = 0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (bus.req_ready) rdy_seen = 1;
    end
    total++;
    if (rdy_seen) begin
      bad++;
      $display("FAIL gap_busy_ready got=1 want=0");
    end
    bus.act_bsy = 1'b0;
    k = 0;
    while (!bus.req_ready && k < 50) begin
      @(posedge clk); @(negedge clk); k++;
    end
    total++;
    if (k != IDLE_GAP + 1) begin
      bad++;
      $display("FAIL gap_rise got=%0d want=%0d",
               k, IDLE_GAP + 1);
    end
    total++;
    if (cs_events != base) begin
      bad++;
      $display("FAIL gap_no_cs got=%0d want=0",
               cs_events - base);
    end
  endtask

  task automatic test_directed_table();
    int want;
    clear_mem();
    mem[3] = '{1'b1, 4'd2, 8'd5};
    mem[7] = '{1'b1, 4'd2, 8'd5};
    mem[9] = '{1'b1, 4'd2, 8'd6};
    run_scan(4'd2, 8'd5, -1, 1'b0, "table");
`ifdef ACT_DEALLOC_RESID_MATCH_EN
    want = 2;
`else
    want = 3;
`endif
    total++;
    if (bus.done_count !== CW'(want)) begin
      bad++;
      $display("FAIL table_const got=%0d want=%0d",
               bus.done_count, want);
    end
  endtask

  task automatic test_no_match();
    clear_mem();
    for (int i = 0; i < BC; i++)
      mem[i] = '{1'($urandom), 4'd3, resid_t'($urandom)};
    mem[5] = '{1'b0, 4'd2, 8'd5};
    run_scan(4'd2, 8'd5, -1, 1'b0, "no_match");
  endtask

  task automatic test_all_match();
    for (int i = 0; i < BC; i++)
      mem[i] = '{1'b1, 4'd1, 8'd9};
    run_scan(4'd1, 8'd9, -1, 1'b0, "all_match");
  endtask

  task automatic test_abort();
    clear_mem();
    mem[2]  = '{1'b1, 4'd1, 8'd1};
    mem[6]  = '{1'b1, 4'd1, 8'd1};
    mem[12] = '{1'b1, 4'd1, 8'd1};
    run_scan(4'd1, 8'd1, 4, 1'b0, "abort");
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < BC; i++)
        mem[i] = '{1'($urandom),
                   owner_t'($urandom_range(0, 3)),
                   resid_t'($urandom_range(0, 2))};
      run_scan(owner_t'($urandom_range(0, 3)),
               resid_t'($urandom_range(0, 2)),
               -1, 1'b1, "random");
    end
  endtask

  task automatic test_reset_mid_write();
    int n, base;
    bit seen;
    clear_mem();
    mem[BC-1] = '{1'b1, 4'd7, 8'd3};
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(posedge clk); @(negedge clk); n++;
    end
    bus.req_valid = 1'b1;
    bus.req_owner = 4'd7;
    bus.req_res_id = 8'd3;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!(bus.act_cs && bus.act_we &&
             int'(bus.act_addr) == BC - 1) && n < 4 * BC) begin
      @(posedge clk); @(negedge clk); n++;
    end
    total++;
    if (n >= 4 * BC) begin
      bad++;
      $display("FAIL rst_write_wait cycles=%0d", n);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    base = cs_events;
    total++;
    if ({bus.act_cs, bus.done_valid, bus.req_ready} !== 3'b0) begin
      bad++;
      $display("FAIL rst_mid got=%b want=000",
               {bus.act_cs, bus.done_valid, bus.req_ready});
    end
    seen = 0;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      if (bus.act_cs || bus.done_valid) seen = 1;
    end
    total++;
    if (seen || cs_events != base) begin
      bad++;
      $display("FAIL rst_quiet got=%0d want=0",
               cs_events - base);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_owner = '0;
    bus.req_res_id = '0;
    bus.act_bsy = 1'b1;
    clear_mem();
    test_reset();
    test_directed_table();
    test_no_match();
    test_all_match();
    test_abort();
    test_random();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
